ram64_arbiter: RTL
==================

Name: ram64_arbiter

Overview:
- Shares one RAM64 instance between two requesters, A and B, using round-robin arbitration and a req/ack handshake.
- After reset it can sweep all 64 locations to a fixed value before serving any request.
- Sits between RAM64 and its clients and drives RAM64's in/address/load pins directly.

Parameters:
- CLEAR_ON_RESET, 1, 1 = run the 64-word clear sweep after reset; 0 = go straight to IDLE.
- CLEAR_VALUE, 16'h0000, data written to every location during the sweep.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a_req  input  1  requester A access request; held high until a_ack.
- a_we  input  1  A: 1 = write, 0 = read; stable while a_req is high.
- a_addr  input  6  A word address; stable while a_req is high.
- a_wdata  input  16  A write data; stable while a_req is high.
- a_ack  output  1  one-cycle pulse: A's access completed.
- a_rdata  output  16  A read data; valid in the a_ack cycle and held until A's next ack.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as A, for requester B.
- busy  output  1  high while the clear sweep runs.
- ram_in  output  16  to RAM64 in.
- ram_address  output  6  to RAM64 address.
- ram_load  output  1  to RAM64 load.
- ram_out  input  16  from RAM64 out (combinational read of ram_address).

Behaviour:
- Reset (clk edge with reset=1):
  - state <= CLEAR if CLEAR_ON_RESET, else IDLE.
  - clr_cnt <= 0, last_grant <= B (so A wins the first tie).
  - a_ack, b_ack, a_rdata, b_rdata <= 0.
  - While reset is high, ram_load is forced to 0.
- Reset mid-operation: an in-flight access is abandoned with no ack; a clear sweep restarts from address 0.
- States: CLEAR, IDLE, ACCESS, RESP.
- CLEAR:
  - busy=1, ram_address=clr_cnt, ram_in=CLEAR_VALUE, ram_load=1.
  - clr_cnt increments each cycle.
  - After writing address 63, go to IDLE; clr_cnt wraps to 0 and is unused afterwards.
  - Requests are ignored (no ack) for the whole sweep.
  - Sweep length: exactly 64 cycles after the reset edge.
- IDLE:
  - busy=0, ram_load=0.
  - If no request, stay in IDLE.
  - If only one requester is high, grant it.
  - If both are high, grant the one that is not last_grant.
  - On grant: latch owner, we, addr, wdata into internal registers; set last_grant <= owner; go to ACCESS.
- ACCESS (1 cycle):
  - ram_address=latched addr, ram_in=latched wdata, ram_load=latched we.
  - For a read, capture ram_out into the owner's rdata register at the end of the cycle.
  - For a write, the owner's rdata is unchanged.
  - Go to RESP.
- RESP (1 cycle):
  - owner's ack=1 (registered), ram_load=0; return to IDLE.
  - The requester may drop req in the ack cycle or keep it high to issue a new request.
  - The new request is re-arbitrated in the following IDLE cycle.
- Latency: req sampled in IDLE at edge N; ACCESS is cycle N+1; ack is high in cycle N+2.
- Peak throughput: one access per 3 cycles.
- Write visibility: RAM64 holds the new value from the cycle after ACCESS, so a read issued after the ack returns it.
- Fairness: with both requesters continuously high, grants alternate A, B, A, B; neither waits more than one access.
- Req/we/addr/wdata changing after the grant has no effect; the latched copy is used.
- The unused requester's ack stays 0.
- When not in CLEAR or ACCESS: ram_address=0, ram_in=0.

Test Plan:
- Reset, CLEAR_ON_RESET=1, CLEAR_VALUE=16'hA5A5 -> busy=1 for exactly 64 cycles with ram_load=1 and ram_address 0..63; afterwards, reads of addresses 0, 31 and 63 return 16'hA5A5.
- After the sweep, A writes 16'h1234 to address 42, then A reads address 42 -> a_ack exactly 2 cycles after each IDLE sample; a_rdata=16'h1234; b_ack stays 0.
- A and B both request on the same cycle (A reads address 5, B writes 16'hBEEF to address 5), both held high -> A is acked first with the old value, B is acked 3 cycles later, and a following A read of address 5 returns 16'hBEEF.
- A and B hold req high for 6 accesses each -> ack order A, B, A, B, ...; acks spaced 3 cycles apart.
- a_req asserted during CLEAR at cycle 10 -> no a_ack until after busy falls; the first ack comes 2 cycles after the first IDLE cycle.
- Reset asserted in the ACCESS cycle of a B write to address 7 -> no b_ack; the sweep restarts at address 0, and address 7 reads CLEAR_VALUE afterwards.

Source files
------------

// File: rtl/ram64_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : ram64_arbiter_if
// Brief    : Requester A/B handshake buses plus the RAM64 pin bundle.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface ram64_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [5:0]  a_addr;
    logic [15:0] a_wdata;
    logic        a_ack;
    logic [15:0] a_rdata;
    logic        b_req;
    logic        b_we;
    logic [5:0]  b_addr;
    logic [15:0] b_wdata;
    logic        b_ack;
    logic [15:0] b_rdata;
    logic        busy;
    logic [15:0] ram_in;
    logic [5:0]  ram_address;
    logic        ram_load;
    logic [15:0] ram_out;

    // The arbiter serves requests, so it takes the slave side.
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  ram_out,
        output a_ack, a_rdata, b_ack, b_rdata,
        output busy, ram_in, ram_address, ram_load
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output ram_out,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  busy, ram_in, ram_address, ram_load
    );
endinterface
`default_nettype wire

// File: rtl/ram64_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : ram64_arbiter
// Brief    : Round-robin req/ack arbiter sharing one RAM64 between A and B,
//            with an optional 64-word clear sweep after reset.
// Revision : 1.0
// ---------------------------------------------------------------------------
module ram64_arbiter #(
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [15:0] CLEAR_VALUE    = 16'h0000
) (
    input  wire logic      clk,
    input  wire logic      reset,
    ram64_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_CLEAR  = 2'd0,
        S_IDLE   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic c_owner_a = 1'b0;
    localparam logic c_owner_b = 1'b1;

    state_t      r_state;
    state_t      w_next_state;
    logic [5:0]  r_clr_cnt;
    logic        r_last_grant;
    logic        r_owner;
    logic        r_we;
    logic [5:0]  r_addr;
    logic [15:0] r_wdata;
    logic        r_a_ack;
    logic        r_b_ack;
    logic [15:0] r_a_rdata;
    logic [15:0] r_b_rdata;

    logic        w_grant_valid;
    logic        w_grant;
    logic        w_busy;
    logic [15:0] w_ram_in;
    logic [5:0]  w_ram_address;
    logic        w_ram_load;

    always_comb begin
        w_grant_valid = bus.a_req | bus.b_req;
        // B wins when alone, or on a tie when A held the previous grant.
        w_grant       = bus.b_req & (~bus.a_req | (r_last_grant == c_owner_a));
        w_next_state  = r_state;
        w_busy        = 1'b0;
        w_ram_in      = 16'h0000;
        w_ram_address = 6'd0;
        w_ram_load    = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_busy        = 1'b1;
                w_ram_address = r_clr_cnt;
                w_ram_in      = CLEAR_VALUE;
                w_ram_load    = 1'b1;
                if (r_clr_cnt == 6'd63) begin
                    w_next_state = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_grant_valid) begin
                    w_next_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_ram_address = r_addr;
                w_ram_in      = r_wdata;
                w_ram_load    = r_we;
                w_next_state  = S_RESP;
            end
            S_RESP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            r_clr_cnt    <= 6'd0;
            r_last_grant <= c_owner_b;
            r_owner      <= c_owner_a;
            r_we         <= 1'b0;
            r_addr       <= 6'd0;
            r_wdata      <= 16'h0000;
            r_a_ack      <= 1'b0;
            r_b_ack      <= 1'b0;
            r_a_rdata    <= 16'h0000;
            r_b_rdata    <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 6'd1;
                end
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_we         <= w_grant ? bus.b_we    : bus.a_we;
                        r_addr       <= w_grant ? bus.b_addr  : bus.a_addr;
                        r_wdata      <= w_grant ? bus.b_wdata : bus.a_wdata;
                    end
                end
                S_ACCESS: begin
                    // Ack is registered here so it is high during RESP.
                    if (r_owner == c_owner_b) begin
                        r_b_ack <= 1'b1;
                        if (!r_we) begin
                            r_b_rdata <= bus.ram_out;
                        end
                    end else begin
                        r_a_ack <= 1'b1;
                        if (!r_we) begin
                            r_a_rdata <= bus.ram_out;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.a_ack       = r_a_ack;
    assign bus.b_ack       = r_b_ack;
    assign bus.a_rdata     = r_a_rdata;
    assign bus.b_rdata     = r_b_rdata;
    assign bus.busy        = w_busy;
    assign bus.ram_in      = w_ram_in;
    assign bus.ram_address = w_ram_address;
    assign bus.ram_load    = w_ram_load & ~reset;

endmodule
`default_nettype wire
